// File: rtl/bp_fe_instr_packer.sv
// bp_fe_instr_packer: packs a PC-tagged 16/32-bit instruction stream into aligned 32-bit words with halfword masks
module bp_fe_instr_packer #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     instr_v_i,
  input  logic [vaddr_width_p-1:0] instr_pc_i,
  input  logic [31:0]              instr_i,
  output logic                     instr_ready_and_o,
  input  logic                     flush_i,
  output logic                     word_v_o,
  output logic [vaddr_width_p-1:0] word_addr_o,
  output logic [31:0]              word_data_o,
  output logic [1:0]               word_mask_o,
  input  logic                     word_ready_and_i,
  output logic                     idle_o
);
  localparam int instr_width_gp = 32;
  localparam int cinstr_width_gp = 16;
  typedef logic [vaddr_width_p-1:0] vaddr_t;
  vaddr_t pc, w, acc_addr, acc_addr_n, out_addr, e_addr;
  logic [cinstr_width_gp-1:0] acc_lo, acc_lo_n;
  logic [instr_width_gp-1:0] out_data, e_data;
  logic [1:0] out_mask, e_mask;
  logic acc_v, acc_v_n, out_v, comp, contig, drain, out_free, would_emit, accept, emit;
  assign pc = instr_pc_i & ~vaddr_t'(1);
  assign w = pc & ~vaddr_t'(3);
  assign comp = instr_i[1:0] != 2'b11;
  assign contig = pc == acc_addr + vaddr_t'(2);
  assign drain = acc_v & (flush_i | (instr_v_i & ~contig));
  assign out_free = ~out_v | word_ready_and_i;
  assign would_emit = acc_v | pc[1] | ~comp;
  assign instr_ready_and_o = ~reset_i & ~drain & (out_free | ~would_emit);
  assign accept = instr_v_i & instr_ready_and_o;
  always_comb begin
    acc_v_n = acc_v;
    acc_addr_n = acc_addr;
    acc_lo_n = acc_lo;
    emit = 1'b0;
    e_addr = acc_addr;
    e_data = {16'h0, acc_lo};
    e_mask = 2'b01;
    if (drain) begin
      emit = out_free;
      acc_v_n = ~out_free;
    end else if (accept) begin
      emit = would_emit;
      e_addr = acc_v ? acc_addr : w;
      e_data = acc_v ? {instr_i[15:0], acc_lo} : pc[1] ? {instr_i[15:0], 16'h0} : instr_i;
      e_mask = (acc_v | ~pc[1]) ? 2'b11 : 2'b10;
      acc_v_n = comp ? (~acc_v & ~pc[1]) : (acc_v | pc[1]);
      acc_addr_n = acc_v ? acc_addr + vaddr_t'(4) : pc[1] ? w + vaddr_t'(4) : w;
      acc_lo_n = comp ? instr_i[15:0] : instr_i[31:16];
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_v <= 1'b0;
      acc_addr <= '0;
      acc_lo <= '0;
      out_v <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_mask <= '0;
    end else begin
      acc_v <= acc_v_n;
      acc_addr <= acc_addr_n;
      acc_lo <= acc_lo_n;
      out_v <= emit | (out_v & ~word_ready_and_i);
      if (emit) begin
        out_addr <= e_addr;
        out_data <= e_data;
        out_mask <= e_mask;
      end
    end
  end
  assign word_v_o = out_v;
  assign word_addr_o = out_addr;
  assign word_data_o = out_data;
  assign word_mask_o = out_mask;
  assign idle_o = ~acc_v & ~out_v;
endmodule

// File: tb/tb_bp_fe_instr_packer.sv
// tb_bp_fe_instr_packer: directed and randomized self-checking bench for bp_fe_instr_packer
module tb_bp_fe_instr_packer;
  localparam int W = 39;
  typedef logic [W+34:0] ow_t;
  logic clk_i = 0, reset_i = 1, instr_v_i = 0, flush_i = 0, word_ready_and_i = 1;
  logic [W-1:0] instr_pc_i = '0;
  logic [31:0] instr_i = '0;
  logic instr_ready_and_o, word_v_o, idle_o;
  logic [W-1:0] word_addr_o;
  logic [31:0] word_data_o;
  logic [1:0] word_mask_o;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  bp_fe_instr_packer #(.vaddr_width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .instr_v_i(instr_v_i), .instr_pc_i(instr_pc_i),
    .instr_i(instr_i), .instr_ready_and_o(instr_ready_and_o), .flush_i(flush_i),
    .word_v_o(word_v_o), .word_addr_o(word_addr_o), .word_data_o(word_data_o),
    .word_mask_o(word_mask_o), .word_ready_and_i(word_ready_and_i), .idle_o(idle_o)
  );
  function automatic ow_t obs();
    return {word_v_o, word_addr_o, word_data_o, word_mask_o};
  endfunction
  function automatic ow_t wexp(logic v, logic [W-1:0] a, logic [31:0] d, logic [1:0] m);
    return {v, a, d, m};
  endfunction
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    reset_i = 1; instr_v_i = 0; flush_i = 0; word_ready_and_i = 1;
    cyc(); cyc();
    checks++; if (obs() !== wexp(0, 0, 0, 0)) begin errors++; $display("FAIL reset_word got %h exp %h", obs(), wexp(0, 0, 0, 0)); end
    checks++; if ({idle_o, instr_ready_and_o} !== 2'b10) begin errors++; $display("FAIL reset_idle_ready got %b exp 10", {idle_o, instr_ready_and_o}); end
    reset_i = 0;
    cyc();
    checks++; if (instr_ready_and_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", instr_ready_and_o); end
  endtask
  task automatic test_aligned32();
    instr_v_i = 1; instr_pc_i = 'h1000; instr_i = 'h00A00093;
    #1;
    checks++; if (instr_ready_and_o !== 1'b1) begin errors++; $display("FAIL a32_ready got %b exp 1", instr_ready_and_o); end
    cyc();
    instr_v_i = 0;
    checks++; if (obs() !== wexp(1, 'h1000, 'h00A00093, 2'b11)) begin errors++; $display("FAIL a32_word got %h exp %h", obs(), wexp(1, 'h1000, 'h00A00093, 2'b11)); end
    cyc();
    checks++; if ({word_v_o, idle_o} !== 2'b01) begin errors++; $display("FAIL a32_idle got %b exp 01", {word_v_o, idle_o}); end
  endtask
  task automatic test_two_compressed();
    instr_v_i = 1; instr_pc_i = 'h2000; instr_i = 'h4505;
    cyc();
    instr_pc_i = 'h2002; instr_i = 'h8082;
    #1;
    checks++; if ({word_v_o, instr_ready_and_o} !== 2'b01) begin errors++; $display("FAIL c16_first got %b exp 01", {word_v_o, instr_ready_and_o}); end
    cyc();
    instr_v_i = 0;
    checks++; if (obs() !== wexp(1, 'h2000, 'h80824505, 2'b11)) begin errors++; $display("FAIL c16_word got %h exp %h", obs(), wexp(1, 'h2000, 'h80824505, 2'b11)); end
    cyc();
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL c16_idle got %b exp 1", idle_o); end
  endtask
  task automatic test_straddle();
    instr_v_i = 1; instr_pc_i = 'h3002; instr_i = 'h00B50533;
    cyc();
    instr_v_i = 0; flush_i = 1;
    checks++; if (obs() !== wexp(1, 'h3000, 'h05330000, 2'b10)) begin errors++; $display("FAIL strad_hi got %h exp %h", obs(), wexp(1, 'h3000, 'h05330000, 2'b10)); end
    checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL strad_busy got %b exp 0", idle_o); end
    cyc();
    flush_i = 0;
    checks++; if (obs() !== wexp(1, 'h3004, 'h000000B5, 2'b01)) begin errors++; $display("FAIL strad_lo got %h exp %h", obs(), wexp(1, 'h3004, 'h000000B5, 2'b01)); end
    cyc();
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL strad_idle got %b exp 1", idle_o); end
  endtask
  task automatic test_discontinuity();
    instr_v_i = 1; instr_pc_i = 'h4000; instr_i = 'h4505;
    cyc();
    instr_pc_i = 'h5000; instr_i = 'h00000013;
    #1;
    checks++; if (instr_ready_and_o !== 1'b0) begin errors++; $display("FAIL disc_stall got %b exp 0", instr_ready_and_o); end
    cyc();
    checks++; if (obs() !== wexp(1, 'h4000, 'h00004505, 2'b01)) begin errors++; $display("FAIL disc_part got %h exp %h", obs(), wexp(1, 'h4000, 'h00004505, 2'b01)); end
    checks++; if (instr_ready_and_o !== 1'b1) begin errors++; $display("FAIL disc_resume got %b exp 1", instr_ready_and_o); end
    cyc();
    instr_v_i = 0;
    checks++; if (obs() !== wexp(1, 'h5000, 'h00000013, 2'b11)) begin errors++; $display("FAIL disc_next got %h exp %h", obs(), wexp(1, 'h5000, 'h00000013, 2'b11)); end
    cyc();
  endtask
  task automatic test_flush_empty();
    flush_i = 1; instr_v_i = 1; instr_pc_i = 'h8000; instr_i = 'h00500293;
    #1;
    checks++; if (instr_ready_and_o !== 1'b1) begin errors++; $display("FAIL fe_ready got %b exp 1", instr_ready_and_o); end
    cyc();
    flush_i = 0; instr_v_i = 0;
    checks++; if (obs() !== wexp(1, 'h8000, 'h00500293, 2'b11)) begin errors++; $display("FAIL fe_word got %h exp %h", obs(), wexp(1, 'h8000, 'h00500293, 2'b11)); end
    cyc();
  endtask
  task automatic test_wrap();
    logic [W-1:0] top;
    top = '1;
    top = top - 2'd1;
    instr_v_i = 1; instr_pc_i = top; instr_i = 'h12345677;
    cyc();
    instr_v_i = 0; flush_i = 1;
    checks++; if (obs() !== wexp(1, top - 2'd2, 'h56770000, 2'b10)) begin errors++; $display("FAIL wrap_hi got %h exp %h", obs(), wexp(1, top - 2'd2, 'h56770000, 2'b10)); end
    cyc();
    flush_i = 0;
    checks++; if (obs() !== wexp(1, 0, 'h00001234, 2'b01)) begin errors++; $display("FAIL wrap_lo got %h exp %h", obs(), wexp(1, 0, 'h00001234, 2'b01)); end
    cyc();
  endtask
  task automatic test_backpressure();
    logic [31:0] ins [3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    int i = 0, k = 0, early = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      word_ready_and_i = (c >= 5);
      instr_v_i = (i < 3);
      instr_pc_i = W'('h7000 + 4 * i);
      instr_i = ins[i < 3 ? i : 2];
      #1;
      if (c >= 1 && c < 5) begin
        checks++; if (obs() !== wexp(1, 'h7000, ins[0], 2'b11)) begin errors++; $display("FAIL bp_hold got %h exp %h", obs(), wexp(1, 'h7000, ins[0], 2'b11)); end
      end
      if (word_v_o && word_ready_and_i) begin
        checks++; if (obs() !== wexp(1, W'('h7000 + 4 * k), ins[k], 2'b11)) begin errors++; $display("FAIL bp_word%0d got %h exp %h", k, obs(), wexp(1, W'('h7000 + 4 * k), ins[k], 2'b11)); end
        k++;
      end
      if (instr_v_i && instr_ready_and_o) begin
        i++;
        if (c < 5) early++;
      end
      cyc();
    end
    instr_v_i = 0; word_ready_and_i = 1;
    checks++; if (k != 3 || early != 1) begin errors++; $display("FAIL bp_count got words=%0d early=%0d exp 3 1", k, early); end
    cyc();
  endtask
  task automatic test_reset_mid();
    instr_v_i = 1; instr_pc_i = 'h6000; instr_i = 'h4505;
    cyc();
    instr_v_i = 0;
    checks++; if ({word_v_o, idle_o} !== 2'b00) begin errors++; $display("FAIL rm_held got %b exp 00", {word_v_o, idle_o}); end
    reset_i = 1;
    #1;
    checks++; if (instr_ready_and_o !== 1'b0) begin errors++; $display("FAIL rm_ready got %b exp 0", instr_ready_and_o); end
    cyc();
    checks++; if ({word_v_o, idle_o} !== 2'b01) begin errors++; $display("FAIL rm_reset got %b exp 01", {word_v_o, idle_o}); end
    reset_i = 0; flush_i = 1;
    cyc();
    flush_i = 0;
    checks++; if ({word_v_o, idle_o} !== 2'b01) begin errors++; $display("FAIL rm_flush got %b exp 01", {word_v_o, idle_o}); end
    cyc();
  endtask
  task automatic test_random();
    localparam int N = 400;
    logic [W-1:0] pend_a, pc, pcm, a;
    logic [15:0] pend_d, d;
    logic [W+33:0] q[$];
    logic [W+33:0] e;
    bit pend_v = 0, have = 0, cmp, out_free;
    int acc = 0;
    reset_i = 1;
    cyc();
    reset_i = 0;
    pc = 'h10000;
    pend_a = '0; pend_d = '0;
    for (int c = 0; c < 20000; c++) begin
      if (acc >= N && !pend_v && q.size() == 0 && !word_v_o) break;
      if (acc < N && !have && $urandom_range(0, 4) != 0) begin
        have = 1;
        if ($urandom_range(0, 9) == 0) pc = W'($urandom) & ~W'(1);
        instr_i = $urandom;
        instr_i[1:0] = $urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(0, 2));
        instr_pc_i = {pc[W-1:1], 1'($urandom_range(0, 1))};
      end
      instr_v_i = have;
      flush_i = (acc >= N) ? 1'b1 : ($urandom_range(0, 9) == 0);
      word_ready_and_i = (acc >= N) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #1;
      out_free = !word_v_o || word_ready_and_i;
      if (word_v_o && word_ready_and_i) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_extra got %h exp none", obs()); end
        else begin
          e = q.pop_front();
          if (obs() !== {1'b1, e}) begin errors++; $display("FAIL rand_word got %h exp %h", obs(), {1'b1, e}); end
        end
      end
      pcm = instr_pc_i & ~W'(1);
      if (pend_v && (flush_i || (instr_v_i && pcm != pend_a + W'(2)))) begin
        if (instr_v_i) begin
          checks++; if (instr_ready_and_o !== 1'b0) begin errors++; $display("FAIL rand_stall got %b exp 0", instr_ready_and_o); end
        end
        if (out_free) begin
          q.push_back({pend_a, 16'h0, pend_d, 2'b01});
          pend_v = 0;
        end
      end else if (instr_v_i && instr_ready_and_o) begin
        cmp = instr_i[1:0] != 2'b11;
        for (int h = 0; h < (cmp ? 1 : 2); h++) begin
          a = pcm + W'(2 * h);
          d = (h == 1) ? instr_i[31:16] : instr_i[15:0];
          if (pend_v && a == pend_a + W'(2)) begin
            q.push_back({pend_a, d, pend_d, 2'b11});
            pend_v = 0;
          end else if (a[1]) q.push_back({a - W'(2), d, 16'h0, 2'b10});
          else begin
            pend_a = a; pend_d = d; pend_v = 1;
          end
        end
        pc = pcm + (cmp ? W'(2) : W'(4));
        have = 0;
        acc++;
      end
      cyc();
    end
    instr_v_i = 0; flush_i = 0; word_ready_and_i = 1;
    checks++; if (acc != N || q.size() != 0 || pend_v || idle_o !== 1'b1) begin errors++; $display("FAIL rand_end got acc=%0d q=%0d pend=%0d idle=%b exp %0d 0 0 1", acc, q.size(), pend_v, idle_o, N); end
  endtask
  initial begin
    test_reset();
    test_aligned32();
    test_two_compressed();
    test_straddle();
    test_discontinuity();
    test_flush_empty();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
